bc_xfer_sequencer: RTL

//  Bus-controller transfer sequencer for the 1553 core. Runs one BC->RT or RT->BC transfer per start:

---
 rtl/bc_xfer_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/bc_xfer_sequencer.sv
// Bus-controller transfer sequencer: pushes command/data words to the 1553 encoder FIFO,
// then consumes echo/status/data words from the decoder FIFO and reports the outcome.
module bc_xfer_sequencer #(
  parameter int RESP_TIMEOUT = 70000,
  parameter int WORD_TIMEOUT = 400,
  parameter int ECHO_DISCARD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  rt_addr,
  input  logic        tr,
  input  logic [4:0]  subaddr,
  input  logic [4:0]  wcount,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic [15:0] status_word,
  output logic [5:0]  rx_count,
  input  logic        buf_we,
  input  logic [4:0]  buf_addr,
  input  logic [15:0] buf_wdata,
  output logic [15:0] buf_rdata,
  output logic        w_fifo_wd,
  input  logic        w_fifo_unfull,
  output logic [23:0] w_fifo_data,
  output logic        r_fifo_rd,
  input  logic        r_fifo_unempty,
  input  logic [23:0] r_fifo_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CMD       = 3'd1;
  localparam logic [2:0] S_TX_DATA   = 3'd2;
  localparam logic [2:0] S_WAIT_STAT = 3'd3;
  localparam logic [2:0] S_RX_DATA   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [2:0] E_OK      = 3'd0;
  localparam logic [2:0] E_TIMEOUT = 3'd1;
  localparam logic [2:0] E_PARITY  = 3'd2;
  localparam logic [2:0] E_SYNC    = 3'd3;
  localparam logic [2:0] E_ADDR    = 3'd4;
  localparam logic [2:0] E_SHORT   = 3'd5;

  localparam int RW = $clog2(RESP_TIMEOUT + 1);
  localparam int WW = $clog2(WORD_TIMEOUT + 1);

  logic [2:0]    state;
  logic [4:0]    rt_q;
  logic [4:0]    sa_q;
  logic [4:0]    wc_q;
  logic          tr_q;
  logic [5:0]    tx_idx;
  logic [5:0]    echo_left;
  logic [RW-1:0] resp_cnt;
  logic [WW-1:0] word_cnt;
  logic [15:0]   mem [32];

  logic [5:0]  n_words;
  logic [5:0]  echo_init;
  logic [15:0] cmd_word;
  logic        bcast;
  logic        rx_par;
  logic        rx_sync;
  logic        rx_good;
  logic [5:0]  unused_tag;

  assign n_words   = (wc_q == 5'd0) ? 6'd32 : {1'b0, wc_q};
  assign cmd_word  = {rt_q, tr_q, sa_q, wc_q};
  assign bcast     = (rt_q == 5'd31) && !tr_q;
  // Every word we put on the bus comes back once as an echo before the RT answers.
  assign echo_init = (ECHO_DISCARD != 0) ? (tr_q ? 6'd1 : n_words + 6'd1) : 6'd0;
  assign rx_par    = r_fifo_data[17];
  assign rx_sync   = r_fifo_data[16];
  assign rx_good   = (state == S_RX_DATA) && r_fifo_rd && !rx_par && !rx_sync;
  assign unused_tag = r_fifo_data[23:18];

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    w_fifo_wd   = ((state == S_CMD) || (state == S_TX_DATA)) && w_fifo_unfull;
    r_fifo_rd   = r_fifo_unempty &&
                  ((state == S_IDLE) || (state == S_WAIT_STAT) || (state == S_RX_DATA));
    w_fifo_data = 24'd0;
    case (state)
      S_CMD:     w_fifo_data = {8'h01, cmd_word};
      S_TX_DATA: w_fifo_data = {8'h00, mem[tx_idx[4:0]]};
      default:   w_fifo_data = 24'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      err_code    <= E_OK;
      status_word <= 16'd0;
      rx_count    <= 6'd0;
      buf_rdata   <= 16'd0;
      tx_idx      <= 6'd0;
      echo_left   <= 6'd0;
      resp_cnt    <= '0;
      word_cnt    <= '0;
    end else begin
      buf_rdata <= mem[buf_addr];
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CMD;
            err_code <= E_OK;
            rx_count <= 6'd0;
            tx_idx   <= 6'd0;
          end
        end
        // resp_cnt is loaded with 1 on the last push so DONE lands exactly RESP_TIMEOUT cycles later.
        S_CMD: begin
          if (w_fifo_wd) begin
            if (!tr_q) begin
              state  <= S_TX_DATA;
              tx_idx <= 6'd0;
            end else begin
              state     <= S_WAIT_STAT;
              echo_left <= echo_init;
              resp_cnt  <= RW'(1);
            end
          end
        end
        S_TX_DATA: begin
          if (w_fifo_wd) begin
            if (tx_idx == n_words - 6'd1) begin
              if (bcast) begin
                state <= S_DONE;
              end else begin
                state     <= S_WAIT_STAT;
                echo_left <= echo_init;
                resp_cnt  <= RW'(1);
              end
            end else begin
              tx_idx <= tx_idx + 6'd1;
            end
          end
        end
        S_WAIT_STAT: begin
          if (r_fifo_rd && (echo_left == 6'd0)) begin
            if (rx_par) begin
              err_code <= E_PARITY;
              state    <= S_DONE;
            end else if (!rx_sync) begin
              err_code <= E_SYNC;
              state    <= S_DONE;
            end else if (r_fifo_data[15:11] != rt_q) begin
              err_code <= E_ADDR;
              state    <= S_DONE;
            end else begin
              status_word <= r_fifo_data[15:0];
              word_cnt    <= WW'(1);
              state       <= tr_q ? S_RX_DATA : S_DONE;
            end
          end else if (resp_cnt == RW'(RESP_TIMEOUT - 1)) begin
            err_code <= E_TIMEOUT;
            state    <= S_DONE;
          end else begin
            resp_cnt <= resp_cnt + RW'(1);
            if (r_fifo_rd) echo_left <= echo_left - 6'd1;
          end
        end
        S_RX_DATA: begin
          if (r_fifo_rd) begin
            word_cnt <= WW'(1);
            if (rx_par) begin
              err_code <= E_PARITY;
              state    <= S_DONE;
            end else if (rx_sync) begin
              err_code <= E_SYNC;
              state    <= S_DONE;
            end else begin
              rx_count <= rx_count + 6'd1;
              if (rx_count + 6'd1 == n_words) state <= S_DONE;
            end
          end else if (word_cnt == WW'(WORD_TIMEOUT - 1)) begin
            err_code <= E_SHORT;
            state    <= S_DONE;
          end else begin
            word_cnt <= word_cnt + WW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transfer fields and buffer contents carry no reset; host writes only land while idle.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      rt_q <= rt_addr;
      tr_q <= tr;
      sa_q <= subaddr;
      wc_q <= wcount;
    end
    if ((state == S_IDLE) && buf_we) mem[buf_addr] <= buf_wdata;
    if (rx_good) mem[rx_count[4:0]] <= r_fifo_data[15:0];
  end

endmodule
